abacus_top: RTL and testbench

- Wishbone-slave CPU profiling unit that sits beside the RISC-V core and observes issued instructions and I/D-cache activity.
- Contains an instruction profiler (11 class counters) and a cache profiler (6 counters).
- Each profiler is enabled by its own control register; software reads all counters over Wishbone.

---
 rtl/abacus_top.sv | 222 ++++++++++++++++++++++
 tb/tb_abacus_top.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/abacus_top.sv
// ============================================================================
// Module   : abacus_top
// Purpose  : Wishbone-slave CPU profiler counting issued instruction classes
//            and I/D-cache request, miss, hit and line-fill activity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module abacus_top #(
    parameter logic [31:0] ABACUS_BASE_ADDR             = 32'hf0030000,
    parameter logic        INCLUDE_INSTRUCTION_PROFILER = 1'b1,
    parameter logic        INCLUDE_CACHE_PROFILER       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    input  logic [31:0] abacus_instruction,
    input  logic        abacus_instruction_issued,
    input  logic        abacus_icache_request,
    input  logic        abacus_dcache_request,
    input  logic        abacus_icache_miss,
    input  logic        abacus_dcache_hit,
    input  logic        abacus_icache_line_fill_in_progress,
    input  logic        abacus_dcache_line_fill_in_progress
);

    localparam logic [31:0] c_id_value = 32'hABAC0001;
    localparam logic [7:0]  c_off_id       = 8'h00;
    localparam logic [7:0]  c_off_instr_en = 8'h04;
    localparam logic [7:0]  c_off_cache_en = 8'h08;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_op_amo    = 7'b0101111;

    // ---------------------------------------------------------------- bus
    logic        w_sel;
    logic        w_access;
    logic        r_instr_en;
    logic        r_cache_en;
    logic [31:0] w_rdata;

    assign w_sel    = wb_cyc & wb_stb & (wb_adr[31:8] == ABACUS_BASE_ADDR[31:8]);
    // Writes and read capture happen on the edge that raises ack.
    assign w_access = w_sel & ~wb_ack;

    // ---------------------------------------------------------------- decode
    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_is_alu;
    logic       w_is_load, w_is_store, w_is_add, w_is_sub, w_is_logical;
    logic       w_is_shift, w_is_compare, w_is_branch, w_is_jump;
    logic       w_is_system, w_is_atomic;

    assign w_op = abacus_instruction[6:0];
    assign w_f3 = abacus_instruction[14:12];
    assign w_f7 = abacus_instruction[31:25];

    // Register-register ops with funct7 0000001 are M-extension and not counted.
    assign w_is_alu = (w_op == c_op_imm) | ((w_op == c_op_reg) & (w_f7 != 7'b0000001));

    assign w_is_load    = (w_op == c_op_load);
    assign w_is_store   = (w_op == c_op_store);
    assign w_is_add     = ((w_op == c_op_reg) & (w_f3 == 3'b000) & (w_f7 == 7'b0000000))
                        | ((w_op == c_op_imm) & (w_f3 == 3'b000))
                        | (w_op == c_op_lui) | (w_op == c_op_auipc);
    assign w_is_sub     = (w_op == c_op_reg) & (w_f3 == 3'b000) & (w_f7 == 7'b0100000);
    assign w_is_logical = w_is_alu & ((w_f3 == 3'b100) | (w_f3 == 3'b110) | (w_f3 == 3'b111));
    assign w_is_shift   = w_is_alu & ((w_f3 == 3'b001) | (w_f3 == 3'b101));
    assign w_is_compare = w_is_alu & ((w_f3 == 3'b010) | (w_f3 == 3'b011));
    assign w_is_branch  = (w_op == c_op_branch);
    assign w_is_jump    = (w_op == c_op_jal) | (w_op == c_op_jalr);
    assign w_is_system  = (w_op == c_op_system);
    assign w_is_atomic  = (w_op == c_op_amo);

    logic w_unused;
    assign w_unused = ^{abacus_instruction[24:15], abacus_instruction[11:7], wb_dat_i[31:1]};

    // ---------------------------------------------------------------- enables
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack     <= 1'b0;
            wb_dat_o   <= 32'd0;
            r_instr_en <= 1'b0;
            r_cache_en <= 1'b0;
        end else begin
            wb_ack <= w_sel & ~wb_ack;
            if (w_access) begin
                wb_dat_o <= w_rdata;
                if (wb_we && wb_adr[7:0] == c_off_instr_en)
                    r_instr_en <= wb_dat_i[0] & INCLUDE_INSTRUCTION_PROFILER;
                if (wb_we && wb_adr[7:0] == c_off_cache_en)
                    r_cache_en <= wb_dat_i[0] & INCLUDE_CACHE_PROFILER;
            end
        end
    end

    // ---------------------------------------------------------------- instruction counters
    logic [31:0] load_word_counter_reg, store_word_counter_reg, addition_counter_reg;
    logic [31:0] subtraction_counter_reg, logical_bitwise_counter_reg;
    logic [31:0] shift_bitwise_counter_reg, comparison_counter_reg, branch_counter_reg;
    logic [31:0] jump_counter_reg, system_privilege_counter_reg, atomic_counter_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || !r_instr_en) begin
            load_word_counter_reg        <= 32'd0;
            store_word_counter_reg       <= 32'd0;
            addition_counter_reg         <= 32'd0;
            subtraction_counter_reg      <= 32'd0;
            logical_bitwise_counter_reg  <= 32'd0;
            shift_bitwise_counter_reg    <= 32'd0;
            comparison_counter_reg       <= 32'd0;
            branch_counter_reg           <= 32'd0;
            jump_counter_reg             <= 32'd0;
            system_privilege_counter_reg <= 32'd0;
            atomic_counter_reg           <= 32'd0;
        end else if (abacus_instruction_issued) begin
            if (w_is_load)    load_word_counter_reg        <= load_word_counter_reg + 32'd1;
            if (w_is_store)   store_word_counter_reg       <= store_word_counter_reg + 32'd1;
            if (w_is_add)     addition_counter_reg         <= addition_counter_reg + 32'd1;
            if (w_is_sub)     subtraction_counter_reg      <= subtraction_counter_reg + 32'd1;
            if (w_is_logical) logical_bitwise_counter_reg  <= logical_bitwise_counter_reg + 32'd1;
            if (w_is_shift)   shift_bitwise_counter_reg    <= shift_bitwise_counter_reg + 32'd1;
            if (w_is_compare) comparison_counter_reg       <= comparison_counter_reg + 32'd1;
            if (w_is_branch)  branch_counter_reg           <= branch_counter_reg + 32'd1;
            if (w_is_jump)    jump_counter_reg             <= jump_counter_reg + 32'd1;
            if (w_is_system)  system_privilege_counter_reg <= system_privilege_counter_reg + 32'd1;
            if (w_is_atomic)  atomic_counter_reg           <= atomic_counter_reg + 32'd1;
        end
    end

    // ---------------------------------------------------------------- cache counters
    logic        r_icache_request_q, r_icache_miss_q, r_dcache_request_q, r_dcache_hit_q;
    logic [31:0] r_icache_request_cnt, r_icache_miss_cnt, r_icache_fill_cnt;
    logic [31:0] r_dcache_request_cnt, r_dcache_hit_cnt, r_dcache_fill_cnt;

    // Previous-value flops track the inputs regardless of enable so that
    // re-enabling mid-level does not count a stale edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_icache_request_q <= 1'b0;
            r_icache_miss_q    <= 1'b0;
            r_dcache_request_q <= 1'b0;
            r_dcache_hit_q     <= 1'b0;
        end else begin
            r_icache_request_q <= abacus_icache_request;
            r_icache_miss_q    <= abacus_icache_miss;
            r_dcache_request_q <= abacus_dcache_request;
            r_dcache_hit_q     <= abacus_dcache_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || !r_cache_en) begin
            r_icache_request_cnt <= 32'd0;
            r_icache_miss_cnt    <= 32'd0;
            r_icache_fill_cnt    <= 32'd0;
            r_dcache_request_cnt <= 32'd0;
            r_dcache_hit_cnt     <= 32'd0;
            r_dcache_fill_cnt    <= 32'd0;
        end else begin
            if (abacus_icache_request & ~r_icache_request_q)
                r_icache_request_cnt <= r_icache_request_cnt + 32'd1;
            if (abacus_icache_miss & ~r_icache_miss_q)
                r_icache_miss_cnt <= r_icache_miss_cnt + 32'd1;
            if (abacus_icache_line_fill_in_progress)
                r_icache_fill_cnt <= r_icache_fill_cnt + 32'd1;
            if (abacus_dcache_request & ~r_dcache_request_q)
                r_dcache_request_cnt <= r_dcache_request_cnt + 32'd1;
            if (abacus_dcache_hit & ~r_dcache_hit_q)
                r_dcache_hit_cnt <= r_dcache_hit_cnt + 32'd1;
            if (abacus_dcache_line_fill_in_progress)
                r_dcache_fill_cnt <= r_dcache_fill_cnt + 32'd1;
        end
    end

    // ---------------------------------------------------------------- read mux
    always_comb begin
        w_rdata = 32'd0;
        case (wb_adr[7:0])
            c_off_id:       w_rdata = c_id_value;
            c_off_instr_en: w_rdata = {31'd0, r_instr_en};
            c_off_cache_en: w_rdata = {31'd0, r_cache_en};
            8'h0C:          w_rdata = load_word_counter_reg;
            8'h10:          w_rdata = store_word_counter_reg;
            8'h14:          w_rdata = addition_counter_reg;
            8'h18:          w_rdata = subtraction_counter_reg;
            8'h1C:          w_rdata = logical_bitwise_counter_reg;
            8'h20:          w_rdata = shift_bitwise_counter_reg;
            8'h24:          w_rdata = comparison_counter_reg;
            8'h28:          w_rdata = branch_counter_reg;
            8'h2C:          w_rdata = jump_counter_reg;
            8'h30:          w_rdata = system_privilege_counter_reg;
            8'h34:          w_rdata = atomic_counter_reg;
            8'h38:          w_rdata = r_icache_request_cnt;
            8'h3C:          w_rdata = r_icache_miss_cnt;
            8'h40:          w_rdata = r_icache_fill_cnt;
            8'h44:          w_rdata = r_dcache_request_cnt;
            8'h48:          w_rdata = r_dcache_hit_cnt;
            8'h4C:          w_rdata = r_dcache_fill_cnt;
            default:        w_rdata = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_abacus_top.sv
// ============================================================================
// Module   : tb_abacus_top
// Purpose  : Directed self-checking bench for the abacus profiling unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_abacus_top;

    localparam logic [31:0] c_base = 32'hf0030000;

    logic        clk;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
    logic [31:0] abacus_instruction;
    logic        abacus_instruction_issued;
    logic        abacus_icache_request, abacus_dcache_request;
    logic        abacus_icache_miss, abacus_dcache_hit;
    logic        abacus_icache_line_fill_in_progress, abacus_dcache_line_fill_in_progress;

    int n_checks = 0;
    int n_errors = 0;

    abacus_top dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .wb_cyc                              (wb_cyc),
        .wb_stb                              (wb_stb),
        .wb_we                               (wb_we),
        .wb_adr                              (wb_adr),
        .wb_dat_i                            (wb_dat_i),
        .wb_dat_o                            (wb_dat_o),
        .wb_ack                              (wb_ack),
        .abacus_instruction                  (abacus_instruction),
        .abacus_instruction_issued           (abacus_instruction_issued),
        .abacus_icache_request               (abacus_icache_request),
        .abacus_dcache_request               (abacus_dcache_request),
        .abacus_icache_miss                  (abacus_icache_miss),
        .abacus_dcache_hit                   (abacus_dcache_hit),
        .abacus_icache_line_fill_in_progress (abacus_icache_line_fill_in_progress),
        .abacus_dcache_line_fill_in_progress (abacus_dcache_line_fill_in_progress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction; lat is the number of falling edges until ack was seen.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat, output logic acked, output int lat);
        rdat  = 32'hxxxxxxxx;
        acked = 1'b0;
        lat   = 0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wdat;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(negedge clk);
            if (wb_ack) begin
                acked = 1'b1;
                rdat  = wb_dat_o;
                lat   = i + 1;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] d; logic a; int l;
        wb_xfer(1'b0, c_base + {24'd0, off}, 32'd0, d, a, l);
        chk({tag, "_ack"}, {31'd0, a}, 32'd1);
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] dat, input string tag);
        logic [31:0] d; logic a; int l;
        wb_xfer(1'b1, c_base + {24'd0, off}, dat, d, a, l);
        chk({tag, "_ack"}, {31'd0, a}, 32'd1);
    endtask

    task automatic issue(input logic [31:0] instr, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            abacus_instruction = instr;
            abacus_instruction_issued = 1'b1;
            @(negedge clk);
            abacus_instruction_issued = 1'b0;
        end
    endtask

    int          exp_instr [11] = '{7, 3, 12, 2, 6, 6, 8, 6, 0, 5, 7};
    logic [31:0] rdat;
    logic        acked;
    int          lat;

    initial begin
        rst = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 32'd0; wb_dat_i = 32'd0;
        abacus_instruction = 32'd0; abacus_instruction_issued = 1'b0;
        abacus_icache_request = 1'b0; abacus_dcache_request = 1'b0;
        abacus_icache_miss = 1'b0; abacus_dcache_hit = 1'b0;
        abacus_icache_line_fill_in_progress = 1'b0; abacus_dcache_line_fill_in_progress = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ack", {31'd0, wb_ack}, 32'd0);
        chk("reset_dat", wb_dat_o, 32'd0);
        rst = 1'b1;

        // ID read with single-cycle ack latency
        wb_xfer(1'b0, c_base, 32'd0, rdat, acked, lat);
        chk("id_latency", lat, 32'd1);
        chk("id_value", rdat, 32'hABAC0001);
        for (int i = 0; i < 17; i++) rd(8'h0C + 8'(4 * i), 32'd0, "reset_counter");
        rd(8'h04, 32'd0, "reset_instr_en");
        rd(8'h80, 32'd0, "unmapped");
        wb_xfer(1'b0, 32'hf0040000, 32'd0, rdat, acked, lat);
        chk("out_of_window_ack", {31'd0, acked}, 32'd0);

        // Instruction profiler
        wr(8'h04, 32'd1, "instr_en_on");
        rd(8'h04, 32'd1, "instr_en_rb");
        issue(32'h00002003, 4); issue(32'h00004003, 3);
        issue(32'h00002023, 3);
        issue(32'h00000033, 3); issue(32'h00000013, 3); issue(32'h00000037, 3); issue(32'h00000017, 3);
        issue(32'h40000033, 2);
        issue(32'h0000000F, 1); issue(32'h02000033, 1); issue(32'h02004033, 1);
        issue(32'h00004033, 1); issue(32'h00006033, 1); issue(32'h00007033, 1);
        issue(32'h00004013, 1); issue(32'h00006013, 1); issue(32'h00007013, 1);
        issue(32'h00001033, 1); issue(32'h00005033, 1); issue(32'h40005033, 1);
        issue(32'h00001013, 1); issue(32'h00005013, 1); issue(32'h40005013, 1);
        issue(32'h00002033, 2); issue(32'h00003033, 2); issue(32'h00002013, 2); issue(32'h00003013, 2);
        issue(32'h00000063, 1); issue(32'h00001063, 1); issue(32'h00004063, 1);
        issue(32'h00005063, 1); issue(32'h00006063, 1); issue(32'h00007063, 1);
        issue(32'h00000073, 1); issue(32'h00100073, 1); issue(32'h00001073, 1);
        issue(32'h00002073, 1); issue(32'h00003073, 1);
        issue(32'h0000202F, 4); issue(32'h0800302F, 3);
        for (int i = 0; i < 11; i++) rd(8'h0C + 8'(4 * i), 32'(exp_instr[i]), "instr_counter");
        wr(8'h0C, 32'h00000055, "ro_write");
        rd(8'h0C, 32'd7, "ro_write_ignored");
        wr(8'h04, 32'd1, "instr_en_rewrite");
        rd(8'h0C, 32'd7, "rewrite_no_clear");
        issue(32'h0000006F, 1); issue(32'h00000067, 1);
        rd(8'h2C, 32'd2, "jump_counter");

        // Disabling clears and stops counting
        wr(8'h04, 32'd0, "instr_en_off");
        for (int i = 0; i < 11; i++) rd(8'h0C + 8'(4 * i), 32'd0, "instr_cleared");
        issue(32'h00002003, 2);
        rd(8'h0C, 32'd0, "disabled_no_count");

        // Cache profiler, icache side
        wr(8'h08, 32'd1, "cache_en_on");
        @(negedge clk); abacus_icache_request = 1'b1;
        repeat (5) @(negedge clk);
        abacus_icache_request = 1'b0;
        rd(8'h38, 32'd1, "icache_request");
        @(negedge clk); abacus_icache_miss = 1'b1; abacus_icache_line_fill_in_progress = 1'b1;
        repeat (5) @(negedge clk);
        abacus_icache_miss = 1'b0; abacus_icache_line_fill_in_progress = 1'b0;
        rd(8'h3C, 32'd1, "icache_miss");
        rd(8'h40, 32'd5, "icache_fill");

        // dcache side
        @(negedge clk); abacus_dcache_request = 1'b1;
        repeat (5) @(negedge clk);
        abacus_dcache_request = 1'b0;
        rd(8'h44, 32'd1, "dcache_request");
        @(negedge clk); abacus_dcache_hit = 1'b1; abacus_dcache_line_fill_in_progress = 1'b1;
        repeat (5) @(negedge clk);
        abacus_dcache_hit = 1'b0; abacus_dcache_line_fill_in_progress = 1'b0;
        rd(8'h48, 32'd1, "dcache_hit");
        rd(8'h4C, 32'd5, "dcache_fill");
        rd(8'h40, 32'd5, "icache_fill_stable");

        wr(8'h08, 32'd0, "cache_en_off");
        rd(8'h44, 32'd0, "dcache_request_cleared");
        wr(8'h08, 32'd1, "cache_en_again");
        repeat (3) begin
            @(negedge clk); abacus_dcache_request = 1'b1;
            @(negedge clk); abacus_dcache_request = 1'b0;
        end
        rd(8'h44, 32'd3, "dcache_request_toggle");

        // Asynchronous reset mid-run
        wr(8'h04, 32'd1, "instr_en_pre_reset");
        issue(32'h00002003, 2);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_load_counter", dut.load_word_counter_reg, 32'd0);
        chk("async_dcache_req", dut.r_dcache_request_cnt, 32'd0);
        chk("async_instr_en", {31'd0, dut.r_instr_en}, 32'd0);
        chk("async_cache_en", {31'd0, dut.r_cache_en}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        issue(32'h00002003, 2);
        @(negedge clk); abacus_icache_request = 1'b1;
        @(negedge clk); abacus_icache_request = 1'b0;
        rd(8'h0C, 32'd0, "post_reset_load");
        rd(8'h38, 32'd0, "post_reset_icache");
        rd(8'h04, 32'd0, "post_reset_instr_en");
        rd(8'h08, 32'd0, "post_reset_cache_en");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
